// File: rtl/gpio_config_decoder_if.sv
// PS GPIO control bus and decoded configuration/strobe outputs of gpio_config_decoder.
// The slave modport is the decoder side; master is the PS/consumer side.
interface gpio_config_decoder_if #(
  parameter int GPIO_W  = 16,
  parameter int REG_W   = 32,
  parameter int CH_W    = 16,
  parameter int SHIFT_W = 5
);
  logic [GPIO_W-1:0]  gpio_in;
  logic               dac_busy;
  logic [REG_W-1:0]   cycle_count;
  logic [REG_W-1:0]   adc_num_cycles;
  logic [REG_W-1:0]   pre_delay;
  logic [REG_W-1:0]   post_delay;
  logic [SHIFT_W-1:0] adc_shift_val;
  logic               mask_enable;
  logic [CH_W-1:0]    channel_sel;
  logic               sdata_out;
  logic               mask_shift_en;
  logic               mux_shift_en;
  logic               lock_shift_en;
  logic               trigger_pulse;
  logic               adc_flush_pulse;
  logic               soft_rst;
  logic               trig_overrun;

  modport master (
    output gpio_in, dac_busy,
    input  cycle_count, adc_num_cycles, pre_delay, post_delay, adc_shift_val,
           mask_enable, channel_sel, sdata_out, mask_shift_en, mux_shift_en,
           lock_shift_en, trigger_pulse, adc_flush_pulse, soft_rst, trig_overrun
  );

  modport slave (
    input  gpio_in, dac_busy,
    output cycle_count, adc_num_cycles, pre_delay, post_delay, adc_shift_val,
           mask_enable, channel_sel, sdata_out, mask_shift_en, mux_shift_en,
           lock_shift_en, trigger_pulse, adc_flush_pulse, soft_rst, trig_overrun
  );
endinterface

// File: rtl/gpio_config_decoder.sv
// Decodes the asynchronous PS GPIO bus into shadowed configuration registers,
// committed atomically on trigger, plus single-cycle per-channel and control strobes.
module gpio_config_decoder #(
  parameter int GPIO_W      = 16,
  parameter int REG_W       = 32,
  parameter int CH_W        = 16,
  parameter int SHIFT_W     = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  gpio_config_decoder_if.slave bus
);
  localparam int unsigned L_SDATA  = 0;
  localparam int unsigned L_CC     = 1;
  localparam int unsigned L_ADCN   = 2;
  localparam int unsigned L_PRE    = 3;
  localparam int unsigned L_POST   = 4;
  localparam int unsigned L_SHIFT  = 5;
  localparam int unsigned L_MASKEN = 6;
  localparam int unsigned L_CHSEL  = 7;
  localparam int unsigned L_MASK   = 8;
  localparam int unsigned L_MUX    = 9;
  localparam int unsigned L_LOCK   = 10;
  localparam int unsigned L_TRIG   = 11;
  localparam int unsigned L_PLRST  = 12;
  localparam int unsigned L_FLUSH  = 13;

  logic [GPIO_W-1:0]    sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0]    gpio_s;
  logic [GPIO_W-1:0]    prev_q;
  logic [GPIO_W-1:0]    rise;
  logic [SYNC_STAGES:0] arm_q;
  logic                 sdata;
  logic                 commit;
  logic                 unused_bits;

  logic [REG_W-1:0]   cc_sh, adcn_sh, pre_sh, post_sh;
  logic [REG_W-1:0]   cc_nxt, adcn_nxt, pre_nxt, post_nxt;
  logic [REG_W-1:0]   cc_q, adcn_q, pre_q, post_q;
  logic [SHIFT_W-1:0] shift_sh, shift_nxt, shift_q;
  logic               maskv_sh, maskv_nxt, maskv_q;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_nxt;
  logic               sdata_q, mask_q, mux_q, lock_q, trig_q, flush_q, ovr_q;

  assign gpio_s = sync_q[SYNC_STAGES-1];
  assign sdata  = gpio_s[L_SDATA];
  // Edges are masked until the chain and prev hold post-reset samples, so a
  // line held high through reset is not seen as a rising edge.
  assign rise   = arm_q[SYNC_STAGES] ? (gpio_s & ~prev_q) : '0;
  assign commit = rise[L_TRIG] & ~bus.dac_busy;
  assign unused_bits = ^{rise[GPIO_W-1:L_FLUSH+1], rise[L_PLRST], rise[L_SDATA]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q[0] <= bus.gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= gpio_s;
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Next shadow values feed both the shadow and the commit path, so a shift
  // coinciding with a trigger edge is included in that commit.
  always_comb begin
    cc_nxt     = cc_sh;
    adcn_nxt   = adcn_sh;
    pre_nxt    = pre_sh;
    post_nxt   = post_sh;
    shift_nxt  = shift_sh;
    maskv_nxt  = maskv_sh;
    ch_sel_nxt = ch_sel_q;
    if (rise[L_CC])     cc_nxt     = {cc_sh[REG_W-2:0], sdata};
    if (rise[L_ADCN])   adcn_nxt   = {adcn_sh[REG_W-2:0], sdata};
    if (rise[L_PRE])    pre_nxt    = {pre_sh[REG_W-2:0], sdata};
    if (rise[L_POST])   post_nxt   = {post_sh[REG_W-2:0], sdata};
    if (rise[L_SHIFT])  shift_nxt  = {shift_sh[SHIFT_W-2:0], sdata};
    if (rise[L_MASKEN]) maskv_nxt  = sdata;
    if (rise[L_CHSEL])  ch_sel_nxt = {ch_sel_q[CH_W-2:0], sdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_sh    <= '0;
      adcn_sh  <= '0;
      pre_sh   <= '0;
      post_sh  <= '0;
      shift_sh <= '0;
      maskv_sh <= 1'b0;
      cc_q     <= '0;
      adcn_q   <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      shift_q  <= '0;
      maskv_q  <= 1'b0;
      ch_sel_q <= '0;
      sdata_q  <= 1'b0;
      mask_q   <= 1'b0;
      mux_q    <= 1'b0;
      lock_q   <= 1'b0;
      trig_q   <= 1'b0;
      flush_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cc_sh    <= cc_nxt;
      adcn_sh  <= adcn_nxt;
      pre_sh   <= pre_nxt;
      post_sh  <= post_nxt;
      shift_sh <= shift_nxt;
      maskv_sh <= maskv_nxt;
      ch_sel_q <= ch_sel_nxt;
      if (commit) begin
        cc_q    <= cc_nxt;
        adcn_q  <= adcn_nxt;
        pre_q   <= pre_nxt;
        post_q  <= post_nxt;
        shift_q <= shift_nxt;
        maskv_q <= maskv_nxt;
      end
      sdata_q <= sdata;
      mask_q  <= rise[L_MASK];
      mux_q   <= rise[L_MUX];
      lock_q  <= rise[L_LOCK];
      trig_q  <= commit;
      flush_q <= rise[L_FLUSH];
      if (rise[L_TRIG] && bus.dac_busy) ovr_q <= 1'b1;
      else if (rise[L_FLUSH])           ovr_q <= 1'b0;
    end
  end

  assign bus.cycle_count     = cc_q;
  assign bus.adc_num_cycles  = adcn_q;
  assign bus.pre_delay       = pre_q;
  assign bus.post_delay      = post_q;
  assign bus.adc_shift_val   = shift_q;
  assign bus.mask_enable     = maskv_q;
  assign bus.channel_sel     = ch_sel_q;
  assign bus.sdata_out       = sdata_q;
  assign bus.mask_shift_en   = mask_q;
  assign bus.mux_shift_en    = mux_q;
  assign bus.lock_shift_en   = lock_q;
  assign bus.trigger_pulse   = trig_q;
  assign bus.adc_flush_pulse = flush_q;
  assign bus.soft_rst        = gpio_s[L_PLRST];
  assign bus.trig_overrun    = ovr_q;
endmodule

// File: tb/tb_gpio_config_decoder.sv
// Directed self-checking bench for gpio_config_decoder: serial loads, commit,
// overrun/flush, channel strobes, reset mid-shift and pl_rst passthrough.
module tb_gpio_config_decoder;
  localparam int SYNC = 2;
  localparam int L_SDATA = 0, L_CC = 1, L_PRE = 3, L_SHIFT = 5, L_MASKEN = 6;
  localparam int L_CHSEL = 7, L_MASK = 8, L_MUX = 9, L_LOCK = 10, L_TRIG = 11;
  localparam int L_PLRST = 12, L_FLUSH = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpio_config_decoder_if #(.GPIO_W(16), .REG_W(32), .CH_W(16), .SHIFT_W(5)) bus ();

  gpio_config_decoder #(
    .GPIO_W(16), .REG_W(32), .CH_W(16), .SHIFT_W(5), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle away from the active edge.
  int          trig_cnt = 0, flush_cnt = 0, mux_cnt = 0, mask_cnt = 0, lock_cnt = 0;
  logic [31:0] cc_at_trig = '0;
  logic [7:0]  mux_bits = '0;
  always @(negedge clk) begin
    if (bus.trigger_pulse) begin
      trig_cnt++;
      cc_at_trig = bus.cycle_count;
    end
    if (bus.adc_flush_pulse) flush_cnt++;
    if (bus.mask_shift_en)   mask_cnt++;
    if (bus.lock_shift_en)   lock_cnt++;
    if (bus.mux_shift_en) begin
      mux_cnt++;
      mux_bits = {mux_bits[6:0], bus.sdata_out};
    end
  end

  task automatic shift_bits(input int line, input int n, input logic [63:0] val);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.gpio_in[L_SDATA] = val[i];
      bus.gpio_in[line]    = 1'b0;
      repeat (4) @(negedge clk);
      bus.gpio_in[line] = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.gpio_in[line] = 1'b0;
  endtask

  task automatic pulse_line(input int line);
    @(negedge clk);
    bus.gpio_in[line] = 1'b1;
    repeat (6) @(negedge clk);
    bus.gpio_in[line] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int t0, lat, first_hi, hi_cnt;

  initial begin
    bus.gpio_in  = '0;
    bus.dac_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_cycle_count", bus.cycle_count, 32'd0);
    check("rst_channel_sel", {16'd0, bus.channel_sel}, 32'd0);
    check("rst_pulses", {bus.trigger_pulse, bus.adc_flush_pulse, bus.trig_overrun, bus.soft_rst}, 32'd0);

    // 500 into cycle_count; stays 0 until trigger; commit visible with pulse
    shift_bits(L_CC, 32, 64'h0000_01F4);
    check("cc_before_trig", bus.cycle_count, 32'd0);
    t0 = trig_cnt;
    @(negedge clk);
    bus.gpio_in[L_TRIG] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.trigger_pulse && lat == 0) lat = i;
    end
    bus.gpio_in[L_TRIG] = 1'b0;
    repeat (4) @(negedge clk);
    check("trig_latency", lat, SYNC + 1);
    check("trig_pulse_count", trig_cnt - t0, 1);
    check("cc_at_trig", cc_at_trig, 32'd500);

    // Overrun: busy trigger is dropped, flush clears the flag
    shift_bits(L_PRE, 32, 64'd10);
    pulse_line(L_TRIG);
    check("pre_delay_10", bus.pre_delay, 32'd10);
    bus.dac_busy = 1'b1;
    shift_bits(L_PRE, 32, 64'd20);
    t0 = trig_cnt;
    pulse_line(L_TRIG);
    check("busy_no_pulse", trig_cnt - t0, 0);
    check("busy_pre_delay", bus.pre_delay, 32'd10);
    check("overrun_set", bus.trig_overrun, 1);
    t0 = flush_cnt;
    pulse_line(L_FLUSH);
    check("flush_one_pulse", flush_cnt - t0, 1);
    check("overrun_cleared", bus.trig_overrun, 0);
    bus.dac_busy = 1'b0;

    // Channel select then per-channel mux strobes
    shift_bits(L_CHSEL, 16, 64'h0004);
    check("channel_sel", {16'd0, bus.channel_sel}, 32'h0004);
    t0 = mux_cnt;
    mux_bits = '0;
    shift_bits(L_MUX, 3, 64'b101);
    repeat (4) @(negedge clk);
    check("mux_strobe_count", mux_cnt - t0, 3);
    check("mux_sdata_seq", {29'd0, mux_bits[2:0]}, 32'b101);
    check("other_strobes", mask_cnt + lock_cnt, 0);

    // 40 edges into a 5-bit shadow keeps the last 5 bits; busy-time shadow commits now
    shift_bits(L_SHIFT, 40, 64'hFF_FFFF_FFF3);
    shift_bits(L_MASKEN, 1, 64'd1);
    check("shift_val_precommit", {27'd0, bus.adc_shift_val}, 32'd0);
    pulse_line(L_TRIG);
    check("adc_shift_val", {27'd0, bus.adc_shift_val}, 32'd19);
    check("mask_enable", bus.mask_enable, 1);
    check("pre_delay_20", bus.pre_delay, 32'd20);
    check("cc_kept_500", bus.cycle_count, 32'd500);

    // Reset during the 12th pre_delay bit; trigger line held high through reset
    shift_bits(L_PRE, 11, 64'h7FF);
    @(negedge clk);
    bus.gpio_in[L_SDATA] = 1'b1;
    repeat (4) @(negedge clk);
    bus.gpio_in[L_PRE] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.gpio_in[L_TRIG] = 1'b1;
    @(negedge clk);
    check("rst_mid_cc", bus.cycle_count, 32'd0);
    check("rst_mid_pre", bus.pre_delay, 32'd0);
    check("rst_mid_misc", {bus.adc_shift_val, bus.mask_enable, bus.channel_sel, bus.trig_overrun}, 32'd0);
    repeat (2) @(negedge clk);
    t0 = trig_cnt;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("held_high_no_edge", trig_cnt - t0, 0);
    bus.gpio_in[L_TRIG] = 1'b0;
    bus.gpio_in[L_PRE]  = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(L_PRE, 32, 64'h1234_5678);
    pulse_line(L_TRIG);
    check("reload_pre_delay", bus.pre_delay, 32'h1234_5678);
    check("reload_cc_cleared", bus.cycle_count, 32'd0);

    // pl_rst passthrough with synchronizer delay
    @(negedge clk);
    bus.gpio_in[L_PLRST] = 1'b1;
    first_hi = 0;
    hi_cnt   = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (bus.soft_rst) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = i;
      end
      if (i == 10) begin
        @(negedge clk);
        bus.gpio_in[L_PLRST] = 1'b0;
      end
    end
    check("soft_rst_delay", first_hi, SYNC);
    check("soft_rst_width", hi_cnt, 10);
    check("pl_rst_pre_kept", bus.pre_delay, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/gpio_config_decoder.md
Name: gpio_config_decoder

Overview:
- Decodes the PS-driven GPIO control bus into fabric-domain configuration registers and control strobes.
- Sits between the PS GPIO output and the DAC control, ADC capture and per-channel blocks.
- Each serial clock line shifts the shared sdata line (bit 0) into its own shadow register.
- On a PS trigger, the shadow registers are committed atomically to active registers and a one-cycle trigger pulse is issued.

Parameters:
- GPIO_W, 16, width of gpio_in; indices follow the team GPIO bus map (sdata=0 … adc_buffer_flush=13).
- REG_W, 32, width of the cycle-count, ADC cycle-count, pre-delay and post-delay registers.
- CH_W, 16, width of the one-hot channel select register.
- SHIFT_W, 5, width of the ADC averaging shift register.
- SYNC_STAGES, 2, synchronizer depth for gpio_in (minimum 2).

Ports:
- clk  in  1  fabric clock.
- rst  in  1  asynchronous active-high reset.
- gpio_in  in  GPIO_W  raw PS GPIO bus, asynchronous to clk.
- dac_busy  in  1  high while DAC/ADC run is in progress.
- cycle_count  out  REG_W  active run length.
- adc_num_cycles  out  REG_W  active ADC run length.
- pre_delay  out  REG_W  active pre-trigger delay.
- post_delay  out  REG_W  active post-run delay.
- adc_shift_val  out  SHIFT_W  active averaging shift.
- mask_enable  out  1  active mask enable.
- channel_sel  out  CH_W  live (uncommitted) one-hot channel select.
- sdata_out  out  1  synchronized sdata, aligned with the strobes below.
- mask_shift_en, mux_shift_en, lock_shift_en  out  1 each  one-cycle strobes on rising edges of mask_clk, mux_set_clk and locking_waveform_clk.
- trigger_pulse  out  1  one-cycle start pulse.
- adc_flush_pulse  out  1  one-cycle ADC flush pulse.
- soft_rst  out  1  synchronized level of the pl_rst line.
- trig_overrun  out  1  sticky flag: a trigger was dropped because dac_busy was high.

Behaviour:
- Synchronization and edge detection
  - gpio_in passes through a SYNC_STAGES flop chain. One further register holds the previous synchronized value.
  - Rising edge on line k: sync[k] & ~prev[k]. Edge strobes appear SYNC_STAGES+1 cycles after the raw edge.
  - Edges are detected and sdata is sampled on the same synchronized stage. The PS must therefore hold sdata stable for ≥ SYNC_STAGES+2 clk cycles on both sides of every serial clock rising edge.
- Shifting
  - On a rising edge of a register clock line, the shadow shifts MSB-first: shadow <= {shadow[W-2:0], sdata}.
  - Lines and targets: cycle_count_clk, adc_num_cycle_count_clk, pre_delay_cycle_clk, post_delay_cycle_clk, adc_shift_val_clk, mask_enable_clk (1-bit shadow).
  - channel_sel_clk shifts directly into the live channel_sel register, which has no shadow.
  - More than W edges simply discards the oldest bits. No framing or length check.
  - Edges on several lines in the same cycle each shift their own register, all using the same sdata bit.
  - Shadow shifting continues while dac_busy is high; active registers are unaffected.
- Per-channel strobes
  - mask_shift_en, mux_shift_en and lock_shift_en each pulse for exactly 1 cycle per rising edge.
  - sdata_out carries the same sdata sample in that cycle. Downstream channel blocks qualify the strobes with channel_sel.
- Trigger/commit
  - Trigger rising edge with dac_busy=0: in the next cycle, all active registers load from their shadows and trigger_pulse=1 for 1 cycle. Active values are therefore valid in the same cycle as trigger_pulse.
  - Trigger rising edge with dac_busy=1: no commit, no pulse, trig_overrun <= 1.
  - trig_overrun clears only on rst or on an adc_flush_pulse.
  - A shift edge in the same cycle as a trigger edge is applied to the shadow first. The commit in the following cycle includes the shifted bit.
- Flush
  - Rising edge on adc_buffer_flush produces adc_flush_pulse for 1 cycle, SYNC_STAGES+1 cycles after the raw edge. It is independent of dac_busy.
- pl_rst
  - soft_rst equals the synchronized level of the pl_rst line. It has no effect on this block's own state, so the PS can always release it.
- Reset (rst)
  - All synchronizer flops, prev register, shadows, active registers and channel_sel clear to 0.
  - All pulses, trig_overrun and soft_rst are 0.
  - Reset asserted mid-shift or mid-commit discards any partial state. After release, the first edge is detected only if the line transitions low→high after release; a line held high through reset is not treated as an edge.

Test Plan:
- Shift 0x0000_01F4 MSB-first over 32 cycle_count_clk edges, each bit held 4 cycles, then trigger with dac_busy=0 -> cycle_count=500 in the same cycle as the single-cycle trigger_pulse. Before the trigger, cycle_count stays 0.
- Load pre_delay=10 and commit. Shift pre_delay=20 with dac_busy=1, then trigger -> pre_delay stays 10, no trigger_pulse, trig_overrun=1. Pulse adc_buffer_flush -> adc_flush_pulse for 1 cycle and trig_overrun=0.
- Shift 16 channel_sel_clk edges giving 0x0004, then 3 mux_set_clk edges with sdata=1,0,1 -> channel_sel=0x0004 immediately after the 16th edge; exactly 3 mux_shift_en pulses with sdata_out=1,0,1.
- Shift 40 edges into adc_shift_val with final 5 bits 10011, then commit -> adc_shift_val=19.
- Assert rst while the 12th pre_delay bit is being shifted, with cycle_count previously committed as 500 -> all outputs 0 after reset. A full 32-bit reload and commit then yields the correct value.
- Raise pl_rst for 10 cycles -> soft_rst high for 10 cycles, delayed SYNC_STAGES cycles; all active registers unchanged.
